// File: rtl/awmc_pkg.sv
// Shared encodings and stage-duration helper for the multi-mode washing-machine controller.
package awmc_pkg;

  typedef enum logic [2:0] {
    ST_FILL   = 3'b000,
    ST_WASH   = 3'b001,
    ST_RINSE  = 3'b010,
    ST_SPIN   = 3'b011,
    ST_DRAIN  = 3'b100,
    ST_PAUSED = 3'b101,
    ST_IDLE   = 3'b111
  } stage_e;

  typedef enum logic [1:0] {
    MD_NORMAL = 2'b00,
    MD_QUICK  = 2'b01,
    MD_HEAVY  = 2'b10,
    MD_RINSE  = 2'b11
  } mode_e;

  typedef struct packed {
    logic valve;
    logic drain;
    logic motor;
  } act_t;

  function automatic int unsigned half_min1(input int unsigned v);
    return ((v >> 1) == 0) ? 1 : (v >> 1);
  endfunction

  // Stage length in cycles for the given stage and wash mode.
  function automatic int unsigned stage_dur(
    input stage_e      st,
    input mode_e       md,
    input int unsigned fill_t,
    input int unsigned wash_t,
    input int unsigned rinse_t,
    input int unsigned spin_t,
    input int unsigned drain_t
  );
    int unsigned d;
    d = 1;
    case (st)
      ST_FILL:  d = fill_t;
      ST_WASH: begin
        if (md == MD_QUICK)      d = half_min1(wash_t);
        else if (md == MD_HEAVY) d = wash_t << 1;
        else                     d = wash_t;
      end
      ST_RINSE: d = (md == MD_QUICK) ? half_min1(rinse_t) : rinse_t;
      ST_SPIN:  d = spin_t;
      ST_DRAIN: d = drain_t;
      default:  d = 1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/awmc_stage_timer.sv
// In-stage cycle counter with terminal detect and pause save/restore.
module awmc_stage_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_restore,
  input  logic             i_hold,
  input  logic             i_save,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_term;
  logic [CNT_W-1:0] r_saved;

  assign o_last = (r_count == (r_term - CNT_W'(1)));

  always_comb begin
    o_count_nxt = r_count + CNT_W'(1);
    if (i_clear)        o_count_nxt = '0;
    else if (i_restore) o_count_nxt = r_saved;
    else if (i_hold)    o_count_nxt = r_count;
  end

  // Saved value is the count the stage would have reached, so a pause adds no cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_term  <= CNT_W'(1);
      r_saved <= '0;
    end else begin
      r_count <= o_count_nxt;
      if (i_clear || i_restore) r_term  <= i_term;
      if (i_save)               r_saved <= o_last ? '0 : (r_count + CNT_W'(1));
    end
  end

endmodule

// File: rtl/awmc_multimode.sv
// Multi-mode wash cycle controller: stage FSM, rinse pass tracking, latched config, actuator decode.
module awmc_multimode
  import awmc_pkg::*;
#(
  parameter int unsigned FILL_T    = 4,
  parameter int unsigned WASH_T    = 10,
  parameter int unsigned RINSE_T   = 6,
  parameter int unsigned SPIN_T    = 8,
  parameter int unsigned DRAIN_T   = 2,
  parameter int unsigned VALVE_T   = 2,
  parameter int unsigned MAX_RINSE = 3,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic [1:0] rinse_n,
  output logic [2:0] stage,
  output logic [1:0] rinse_idx,
  output logic       valve,
  output logic       drain,
  output logic       motor,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam logic [1:0]       MAX_RN    = 2'(MAX_RINSE);
  localparam logic [CNT_W-1:0] VALVE_CNT = CNT_W'(VALVE_T);

  stage_e     r_stage, r_saved_stage;
  mode_e      r_mode;
  logic [1:0] r_pass, r_rn, r_ridx;
  logic       r_done, r_aborted, r_pend, r_busy;
  act_t       r_act;

  stage_e           w_stage_nxt, w_saved_nxt, w_adv_stage;
  mode_e            w_mode_nxt, w_mode_in;
  logic [1:0]       w_pass_nxt, w_adv_pass, w_rn_nxt, w_rn_in;
  logic             w_done_nxt, w_aborted_nxt, w_pend_nxt;
  logic             w_clear, w_restore, w_hold, w_save, w_last;
  logic [CNT_W-1:0] w_term, w_cnt_nxt;
  act_t             w_act;

  assign w_mode_in = mode_e'(mode);
  assign w_rn_in   = (rinse_n == 2'd0) ? 2'd1 : ((rinse_n > MAX_RN) ? MAX_RN : rinse_n);
  assign w_term    = CNT_W'(stage_dur(w_stage_nxt, w_mode_nxt,
                                      FILL_T, WASH_T, RINSE_T, SPIN_T, DRAIN_T));

  awmc_stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_restore   (w_restore),
    .i_hold      (w_hold),
    .i_save      (w_save),
    .i_term      (w_term),
    .o_count_nxt (w_cnt_nxt),
    .o_last      (w_last)
  );

  // Where the sequence goes if the current stage is allowed to run one more cycle.
  always_comb begin
    w_adv_stage = r_stage;
    w_adv_pass  = r_pass;
    if (w_last) begin
      case (r_stage)
        ST_FILL:  w_adv_stage = ST_WASH;
        ST_WASH:  w_adv_stage = ST_RINSE;
        ST_RINSE: begin
          if (r_pass == (r_rn - 2'd1)) begin
            w_adv_stage = ST_SPIN;
            w_adv_pass  = 2'd0;
          end else begin
            w_adv_pass  = r_pass + 2'd1;
          end
        end
        ST_SPIN:  w_adv_stage = ST_DRAIN;
        ST_DRAIN: w_adv_stage = ST_IDLE;
        default:  w_adv_stage = r_stage;
      endcase
    end
  end

  always_comb begin
    w_stage_nxt   = r_stage;
    w_saved_nxt   = r_saved_stage;
    w_mode_nxt    = r_mode;
    w_rn_nxt      = r_rn;
    w_pass_nxt    = r_pass;
    w_done_nxt    = r_done;
    w_aborted_nxt = r_aborted;
    w_pend_nxt    = r_pend;
    w_clear       = 1'b0;
    w_restore     = 1'b0;
    w_hold        = 1'b0;
    w_save        = 1'b0;
    case (r_stage)
      ST_IDLE: begin
        w_hold = 1'b1;
        if (start) begin
          w_mode_nxt    = w_mode_in;
          w_rn_nxt      = w_rn_in;
          w_pass_nxt    = 2'd0;
          w_done_nxt    = 1'b0;
          w_aborted_nxt = 1'b0;
          w_pend_nxt    = 1'b0;
          w_stage_nxt   = (w_mode_in == MD_RINSE) ? ST_RINSE : ST_FILL;
          w_clear       = 1'b1;
          w_hold        = 1'b0;
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          w_stage_nxt = ST_DRAIN;
          w_pass_nxt  = 2'd0;
          w_pend_nxt  = 1'b1;
          w_clear     = 1'b1;
        end else if (!pause) begin
          w_stage_nxt = r_saved_stage;
          w_restore   = 1'b1;
        end else begin
          w_hold = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_stage_nxt = w_adv_stage;
        w_clear     = w_last;
        if (abort) w_pend_nxt = 1'b1;
        if (w_last) begin
          w_done_nxt    = !(r_pend || abort);
          w_aborted_nxt = r_pend || abort;
          w_pend_nxt    = 1'b0;
        end
      end
      default: begin
        if (abort) begin
          w_stage_nxt = ST_DRAIN;
          w_pass_nxt  = 2'd0;
          w_pend_nxt  = 1'b1;
          w_clear     = 1'b1;
        end else if (pause && (w_adv_stage != ST_DRAIN)) begin
          // Park the advanced position so resuming continues without repeating a cycle.
          w_stage_nxt = ST_PAUSED;
          w_saved_nxt = w_adv_stage;
          w_pass_nxt  = w_adv_pass;
          w_save      = 1'b1;
          w_hold      = 1'b1;
        end else begin
          w_stage_nxt = w_adv_stage;
          w_pass_nxt  = w_adv_pass;
          w_clear     = w_last;
        end
      end
    endcase
  end

  // Actuator decode of the upcoming stage/count, registered alongside the state.
  always_comb begin
    w_act = '0;
    case (w_stage_nxt)
      ST_FILL:  w_act.valve = 1'b1;
      ST_WASH: begin
        w_act.motor = 1'b1;
        w_act.valve = (w_cnt_nxt < VALVE_CNT);
      end
      ST_RINSE: begin
        w_act.motor = 1'b1;
        if (w_cnt_nxt < (w_term >> 1)) w_act.drain = 1'b1;
        else                           w_act.valve = 1'b1;
      end
      ST_SPIN: begin
        w_act.drain = 1'b1;
        w_act.motor = 1'b1;
      end
      ST_DRAIN: w_act.drain = 1'b1;
      default:  w_act = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage       <= ST_IDLE;
      r_saved_stage <= ST_IDLE;
      r_mode        <= MD_NORMAL;
      r_rn          <= 2'd1;
      r_pass        <= 2'd0;
      r_ridx        <= 2'd0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_pend        <= 1'b0;
      r_busy        <= 1'b0;
      r_act         <= '0;
    end else begin
      r_stage       <= w_stage_nxt;
      r_saved_stage <= w_saved_nxt;
      r_mode        <= w_mode_nxt;
      r_rn          <= w_rn_nxt;
      r_pass        <= w_pass_nxt;
      r_ridx        <= (w_stage_nxt == ST_RINSE) ? w_pass_nxt : 2'd0;
      r_done        <= w_done_nxt;
      r_aborted     <= w_aborted_nxt;
      r_pend        <= w_pend_nxt;
      r_busy        <= (w_stage_nxt != ST_IDLE);
      r_act         <= w_act;
    end
  end

  assign stage     = r_stage;
  assign rinse_idx = r_ridx;
  assign valve     = r_act.valve;
  assign drain     = r_act.drain;
  assign motor     = r_act.motor;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_awmc_multimode.sv
// Directed bench for awmc_multimode: whole-cycle tallies against hand-computed stage lengths.
module tb_awmc_multimode;

  logic       clk = 1'b0;
  logic       reset_n, start, pause, abort;
  logic [1:0] mode, rinse_n;
  logic [2:0] stage;
  logic [1:0] rinse_idx;
  logic       valve, drain, motor, busy, done, aborted;

  int n_checks = 0;
  int n_fail   = 0;

  int n_st [8];
  int n_valve, n_drn, n_mot, n_both, n_ridx1, n_pact, busy_n;
  int first_st;

  always #5 clk = ~clk;

  awmc_multimode dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .mode      (mode),
    .rinse_n   (rinse_n),
    .stage     (stage),
    .rinse_idx (rinse_idx),
    .valve     (valve),
    .drain     (drain),
    .motor     (motor),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full cycle from a start pulse; events are placed at busy-cycle index c (1 = first busy cycle).
  task automatic run(input logic [1:0] md, input logic [1:0] rn,
                     input int pause_at, input int pause_len,
                     input int abort_at, input int start_at);
    int c;
    for (int i = 0; i < 8; i++) n_st[i] = 0;
    n_valve = 0; n_drn = 0; n_mot = 0; n_both = 0; n_ridx1 = 0; n_pact = 0;
    @(negedge clk);
    start = 1'b1; mode = md; rinse_n = rn;
    @(negedge clk);
    start = 1'b0;
    first_st = int'(stage);
    c = 1;
    while (busy && c < 400) begin
      n_st[stage]++;
      n_valve += int'(valve);
      n_drn   += int'(drain);
      n_mot   += int'(motor);
      n_both  += int'(valve & drain);
      n_ridx1 += int'(rinse_idx == 2'd1);
      if (stage == 3'b101 && (valve || drain || motor || rinse_idx != 2'd0)) n_pact++;
      if (c == pause_at)             pause = 1'b1;
      if (c == pause_at + pause_len) pause = 1'b0;
      abort = (c == abort_at);
      if (c == start_at) begin
        start = 1'b1; mode = 2'b10;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    pause = 1'b0; abort = 1'b0; start = 1'b0;
    busy_n = c - 1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    mode = 2'b00; rinse_n = 2'd1;
    repeat (2) @(negedge clk);
    chk("rst_stage", int'(stage), 7);
    chk("rst_outs", int'({valve, drain, motor, busy, done, aborted}), 0);
    chk("rst_ridx", int'(rinse_idx), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // normal mode, one rinse
    run(2'b00, 2'd1, 0, 0, 0, 0);
    chk("n_busy", busy_n, 30);
    chk("n_first", first_st, 0);
    chk("n_fill", n_st[0], 4);
    chk("n_wash", n_st[1], 10);
    chk("n_rinse", n_st[2], 6);
    chk("n_spin", n_st[3], 8);
    chk("n_drain", n_st[4], 2);
    chk("n_valve", n_valve, 9);
    chk("n_drain_o", n_drn, 13);
    chk("n_motor", n_mot, 24);
    chk("n_both", n_both, 0);
    chk("n_done", int'(done), 1);
    chk("n_aborted", int'(aborted), 0);
    chk("n_idle", int'(stage), 7);

    // heavy mode, two rinses
    run(2'b10, 2'd2, 0, 0, 0, 0);
    chk("h_busy", busy_n, 46);
    chk("h_wash", n_st[1], 20);
    chk("h_rinse", n_st[2], 12);
    chk("h_ridx1", n_ridx1, 6);
    chk("h_valve", n_valve, 12);
    chk("h_done", int'(done), 1);

    // quick mode
    run(2'b01, 2'd1, 0, 0, 0, 0);
    chk("q_busy", busy_n, 22);
    chk("q_wash", n_st[1], 5);
    chk("q_rinse", n_st[2], 3);
    chk("q_valve", n_valve, 8);

    // rinse-only, three passes
    run(2'b11, 2'd3, 0, 0, 0, 0);
    chk("r_busy", busy_n, 28);
    chk("r_first", first_st, 2);
    chk("r_fill", n_st[0], 0);
    chk("r_rinse", n_st[2], 18);

    // pause from WASH count 4 edge, held 7 edges
    run(2'b00, 2'd1, 9, 7, 0, 0);
    chk("p_busy", busy_n, 37);
    chk("p_paused", n_st[5], 7);
    chk("p_wash", n_st[1], 10);
    chk("p_outs_zero", n_pact, 0);
    chk("p_valve", n_valve, 9);
    chk("p_done", int'(done), 1);

    // abort in RINSE pass 0 count 2
    run(2'b00, 2'd1, 0, 0, 17, 0);
    chk("a_busy", busy_n, 19);
    chk("a_drain", n_st[4], 2);
    chk("a_spin", n_st[3], 0);
    chk("a_aborted", int'(aborted), 1);
    chk("a_done", int'(done), 0);

    // pause and abort on the same edge
    run(2'b00, 2'd1, 9, 1, 9, 0);
    chk("pa_busy", busy_n, 11);
    chk("pa_paused", n_st[5], 0);
    chk("pa_drain", n_st[4], 2);
    chk("pa_aborted", int'(aborted), 1);

    // start during SPIN is ignored
    run(2'b00, 2'd1, 0, 0, 0, 22);
    chk("s_busy", busy_n, 30);
    chk("s_fill", n_st[0], 4);
    chk("s_wash", n_st[1], 10);

    // rinse_n = 0 gives one pass
    run(2'b00, 2'd0, 0, 0, 0, 0);
    chk("z_busy", busy_n, 30);
    chk("z_rinse", n_st[2], 6);
    chk("z_done", int'(done), 1);

    // abort in IDLE does nothing
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ai_stage", int'(stage), 7);
    chk("ai_done", int'(done), 1);
    chk("ai_aborted", int'(aborted), 0);
    chk("ai_busy", int'(busy), 0);

    // asynchronous reset mid-WASH
    @(negedge clk); start = 1'b1; mode = 2'b00; rinse_n = 2'd1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ar_pre_stage", int'(stage), 1);
    chk("ar_pre_valve", int'(valve), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_stage", int'(stage), 7);
    chk("ar_outs", int'({valve, drain, motor, busy}), 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("ar_post_stage", int'(stage), 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/awmc_multimode.md
# awmc_multimode

Parametrised multi-mode washing-machine cycle controller, successor to the fixed-timer AWMC controller. It sequences FILL → WASH → RINSE (×N) → SPIN → DRAIN and adds:
- per-stage programmable durations;
- four wash modes;
- a selectable rinse count;
- pause/resume that preserves the in-stage count;
- an abort path that always drains.

It sits between the front-panel input logic and the valve/drain/motor drivers.

## Interface
- FILL_T, 4: FILL stage length in cycles (≥1)
- WASH_T, 10: nominal WASH length (≥2)
- RINSE_T, 6: length of one rinse pass (even, ≥2)
- SPIN_T, 8: SPIN length (≥1)
- DRAIN_T, 2: final DRAIN length (≥1)
- VALVE_T, 2: cycles the valve stays open at WASH entry (≤WASH_T/2)
- MAX_RINSE, 3: maximum rinse passes (1..3)
- CNT_W, 6: stage counter width; must hold 2*WASH_T−1
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin cycle; honoured only in IDLE
- pause  in  1  level; hold while high
- abort  in  1  pulse; terminate via DRAIN
- mode  in  2  00 normal, 01 quick, 10 heavy, 11 rinse-only; latched at start
- rinse_n  in  2  rinse passes; 0→1, >MAX_RINSE→MAX_RINSE; latched at start
- stage  out  3  current stage code
- rinse_idx  out  2  current rinse pass, 0-based
- valve  out  1  inlet valve open
- drain  out  1  drain open
- motor  out  1  drum motor on
- busy  out  1  stage not IDLE
- done  out  1  sticky: last cycle completed normally
- aborted  out  1  sticky: last cycle ended by abort

## Operation
Stage codes:
- IDLE=3'b111, FILL=000, WASH=001, RINSE=010, SPIN=011, DRAIN=100, PAUSED=101.

Durations are computed at stage entry and latched into the counter's terminal value:
- quick: WASH_T>>1 and RINSE_T>>1, minimum 1.
- heavy: WASH_T<<1.
- All other stages are mode-independent.

Each stage lasts exactly its duration; count runs 0..dur−1 and the stage advances when count==dur−1.

Sequence:
- normal, quick, heavy: FILL, WASH, RINSE×n, SPIN, DRAIN, IDLE.
- rinse-only: RINSE×n, SPIN, DRAIN, IDLE.
- RINSE passes: count resets and rinse_idx increments between passes; rinse_idx returns to 0 on leaving RINSE.

Outputs are a Moore decode of registered stage/count:
- FILL: valve=1.
- WASH: motor=1; valve=1 while count<VALVE_T.
- RINSE: motor=1; drain=1 while count<dur/2, otherwise valve=1.
- SPIN: drain=1, motor=1.
- DRAIN: drain=1.
- IDLE, PAUSED: all outputs 0.
- valve and drain are never both 1.

Control priority per edge: abort > pause > start/advance.
- **pause high in a running stage:** save stage and count, go to PAUSED. Hold while pause stays high.
- **pause low in PAUSED:** restore saved stage and count; the cycle continues without a new start.
- **abort in FILL, WASH, RINSE, SPIN or PAUSED:** go to DRAIN with count=0. On DRAIN completion go to IDLE with aborted=1 and done=0.
- **abort in DRAIN:** count continues, aborted is flagged.
- **abort in IDLE:** ignored.
- **start:** in IDLE it clears done/aborted and latches mode and rinse_n. Outside IDLE it is ignored.
- **pause in IDLE or DRAIN:** ignored. Draining is never interrupted.

## Timing
- Reset values: stage=IDLE; rinse_idx=0; valve, drain, motor, busy, done and aborted all 0; count=0; saved state cleared.
- Reset mid-cycle returns to IDLE immediately (asynchronous). The valve closes in the same instant.
- start sampled high at edge k:
  - stage=FILL during cycle k+1 (RINSE for mode 11);
  - outputs are valid in the same cycle as stage.
- Normal total busy cycles = FILL_T+WASH_T+n·RINSE_T+SPIN_T+DRAIN_T. done rises the cycle stage returns to IDLE.
- Pause sampled at edge k: PAUSED from k+1.
- Resume: pause low at edge j resumes at j+1 with the saved count. Total busy time increases by exactly the number of PAUSED cycles.
- Simultaneous pause and abort: abort wins.
- Simultaneous start and pause in IDLE: start is accepted. PAUSED is entered on the next edge if pause is still high.

## Structure
- Package awmc_pkg: stage encodings, mode encodings, and a function computing stage duration from (stage, mode, parameters).
- Sub-module awmc_stage_timer, CNT_W wide:
  - inputs: load, hold, terminal value;
  - outputs: count, last flag (count==term−1);
  - also provides save/restore of count for pause.
- Top: stage FSM, rinse pass counter, latched config, output decode.

## Test plan
- Defaults, mode 00, rinse_n=1, start pulse → busy 30 cycles: FILL 4, WASH 10, RINSE 6, SPIN 8, DRAIN 2. done=1 after; valve=1 only FILL and WASH cycles 0-1 and RINSE cycles 3-5.
- Mode 10, rinse_n=2 → WASH 20, RINSE 2×6 with rinse_idx 0 then 1, busy 46. Mode 01, rinse_n=1 → busy 22. Mode 11, rinse_n=3 → first stage RINSE, busy 28.
- pause high at WASH count 5 for 7 cycles → stage=101 and all outputs 0 for 7 cycles. WASH resumes at count 5; total busy 37, done=1.
- abort during RINSE pass 0 count 2 → DRAIN next cycle for 2 cycles, then IDLE with aborted=1, done=0. Abort in IDLE → no change.
- Edge cases:
  - start during SPIN → ignored;
  - rinse_n=0 → 1 pass;
  - pause and abort same edge → DRAIN;
  - reset_n low mid-WASH → all outputs 0 asynchronously, stage=IDLE.
